// File: rtl/shift_arbiter_pkg.sv
// Shared execute-stage definitions used by the shift arbiter and its shifter.
// Contents:
//    SHIFT_SLL / SHIFT_SRL / SHIFT_SRA : one-hot shift-type encodings
//    SHIFT_TAG_W                       : default width of the opaque request tag
//    shift_req_t                       : request bundle {s1, s2, kind, tag}
package shift_arbiter_pkg;

   localparam logic [2:0] SHIFT_SLL = 3'b001;
   localparam logic [2:0] SHIFT_SRL = 3'b010;
   localparam logic [2:0] SHIFT_SRA = 3'b100;

   localparam int SHIFT_TAG_W = 4;

   typedef struct packed {
      logic [31:0]            s1;
      logic [4:0]             s2;
      logic [2:0]             kind;
      logic [SHIFT_TAG_W-1:0] tag;
   } shift_req_t;

endpackage

// File: rtl/shift_arbiter_shift.sv
// Combinational 32-bit barrel shifter shared by the execute stage.
// Ports:
//    s1     in  32  operand (treated as signed for SRA)
//    s2     in  5   shift amount
//    kind   in  3   one-hot shift type (SLL/SRL/SRA); lowest set bit wins
//    result out 32  shifted value, 0 when no type bit is set
//    err    out 1   kind is not exactly one of the three legal encodings
module shift_arbiter_shift
   import shift_arbiter_pkg::*;
(
   input  logic [31:0] s1,
   input  logic [4:0]  s2,
   input  logic [2:0]  kind,
   output logic [31:0] result,
   output logic        err
);

   logic signed [31:0] s1_signed;

   assign s1_signed = s1;

   always_comb begin
      result = '0;
      if (kind[0])
         result = s1 << s2;
      else if (kind[1])
         result = s1 >> s2;
      else if (kind[2])
         result = s1_signed >>> s2;
   end

   assign err = !((kind == SHIFT_SLL) || (kind == SHIFT_SRL) || (kind == SHIFT_SRA));

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters
// (port 0: ALU issue, port 1: CSR/address-generation), with a one-entry
// registered response stage.
// Ports:
//    clk, rst                      clock, asynchronous active-high reset
//    flush                         drop held response, block acceptance this cycle
//    reqN_valid/ready              request handshake, N = 0, 1
//    reqN_s1/s2/type/tag           operand, amount, one-hot type, opaque tag
//    rsp_valid/ready               response handshake
//    rsp_result/id/tag/err         registered shift result, winner, tag, type error
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int TAG_W = SHIFT_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_s1,
   input  logic [4:0]       req0_s2,
   input  logic [2:0]       req0_type,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_s1,
   input  logic [4:0]       req1_s2,
   input  logic [2:0]       req1_type,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err
);

   // Round-robin pointer: port favoured when both request (0 after reset).
   logic prio;

   logic             vld_p1;
   logic [31:0]      result_p1;
   logic             id_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             err_p1;

   logic       slot_free;
   logic       can_grant;
   logic       grant0;
   logic       grant1;
   logic       accept;
   shift_req_t req0_bundle;
   shift_req_t req1_bundle;
   shift_req_t sel_p0;
   logic [31:0] shift_result;
   logic        shift_err;

   // ---- stage p0: grant, operand mux, shifter ----
   assign slot_free = !vld_p1 || rsp_ready;
   assign can_grant = slot_free && !flush && !rst;

   // A lone requester wins outright; prio only breaks ties.
   assign grant0 = can_grant && req0_valid && (!req1_valid || !prio);
   assign grant1 = can_grant && req1_valid && (!req0_valid ||  prio);
   assign accept = grant0 || grant1;

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign req0_bundle = '{s1: req0_s1, s2: req0_s2, kind: req0_type,
                          tag: SHIFT_TAG_W'(req0_tag)};
   assign req1_bundle = '{s1: req1_s1, s2: req1_s2, kind: req1_type,
                          tag: SHIFT_TAG_W'(req1_tag)};

   // Mux on the grant itself so the shifter sees the winner's operands.
   assign sel_p0 = grant1 ? req1_bundle : req0_bundle;

   shift_arbiter_shift u_shift (
      .s1     (sel_p0.s1),
      .s2     (sel_p0.s2),
      .kind   (sel_p0.kind),
      .result (shift_result),
      .err    (shift_err)
   );

   // ---- stage p1: response register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         result_p1 <= '0;
         id_p1     <= 1'b0;
         tag_p1    <= '0;
         err_p1    <= 1'b0;
         prio      <= 1'b0;
      end else if (accept) begin
         vld_p1    <= 1'b1;
         result_p1 <= shift_result;
         id_p1     <= grant1;
         tag_p1    <= TAG_W'(sel_p0.tag);
         err_p1    <= shift_err;
         prio      <= !grant1;
      end else if (rsp_ready || flush) begin
         vld_p1    <= 1'b0;
      end
   end

   assign rsp_valid  = vld_p1;
   assign rsp_result = result_p1;
   assign rsp_id     = id_p1;
   assign rsp_tag    = tag_p1;
   assign rsp_err    = err_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a behavioural model checked on every
// falling edge, plus hand-computed expectations for each scenario.
module tb_shift_arbiter;

   localparam logic [2:0] SLL = 3'b001;
   localparam logic [2:0] SRL = 3'b010;
   localparam logic [2:0] SRA = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_s1 = '0, req1_s1 = '0;
   logic [4:0]  req0_s2 = '0, req1_s2 = '0;
   logic [2:0]  req0_type = '0, req1_type = '0;
   logic [3:0]  req0_tag = '0, req1_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_id;
   logic [3:0]  rsp_tag;
   logic        rsp_err;

   int n_cmp = 0;
   int n_fail = 0;

   shift_arbiter #(.TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s1(req0_s1),
      .req0_s2(req0_s2), .req0_type(req0_type), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s1(req1_s1),
      .req1_s2(req1_s2), .req1_type(req1_type), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic        m_valid = 1'b0, m_id = 1'b0, m_err = 1'b0, m_prio = 1'b0;
   logic [31:0] m_result = '0;
   logic [3:0]  m_tag = '0;
   logic        cmp_on = 1'b1;

   function automatic logic [31:0] model_shift(input logic [31:0] a, input logic [4:0] n,
                                                input logic [2:0] k);
      if (k[0]) return a << n;
      if (k[1]) return a >> n;
      if (k[2]) return a[31] ? ((a >> n) | ~(32'hFFFF_FFFF >> n)) : (a >> n);
      return 32'h0;
   endfunction

   // Which port the rules say is accepted now: -1 none, else 0/1.
   function automatic int pick();
      if (rst || flush) return -1;
      if (m_valid && !rsp_ready) return -1;
      if (req0_valid && req1_valid) return m_prio ? 1 : 0;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0; m_result <= '0; m_id <= 1'b0;
         m_tag <= '0; m_err <= 1'b0; m_prio <= 1'b0;
      end else begin
         case (pick())
            0: begin
               m_valid <= 1'b1; m_id <= 1'b0; m_tag <= req0_tag; m_prio <= 1'b1;
               m_result <= model_shift(req0_s1, req0_s2, req0_type);
               m_err <= ($countones(req0_type) != 1);
            end
            1: begin
               m_valid <= 1'b1; m_id <= 1'b1; m_tag <= req1_tag; m_prio <= 1'b0;
               m_result <= model_shift(req1_s1, req1_s2, req1_type);
               m_err <= ($countones(req1_type) != 1);
            end
            default: if (rsp_ready || flush) m_valid <= 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("model_ready0", {31'd0, req0_ready}, {31'd0, pick() == 0});
         check("model_ready1", {31'd0, req1_ready}, {31'd0, pick() == 1});
         check("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
         if (m_valid && !rst) begin
            check("model_rsp_result", rsp_result, m_result);
            check("model_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            check("model_rsp_tag", {28'd0, rsp_tag}, {28'd0, m_tag});
            check("model_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      // Reset state; a valid request during reset must see ready 0.
      req0_valid = 1'b1;
      #12;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_ready0", {31'd0, req0_ready}, 32'd0);
      req0_valid = 1'b0;
      tick();
      rst = 1'b0;

      // Contention: grants alternate 0,1,0,1.
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_s1 = 32'h8000_0000; req0_s2 = 5'd4;  req0_type = SRL; req0_tag = 4'd1;
      req1_valid = 1'b1; req1_s1 = 32'h0000_0001; req1_s2 = 5'd31; req1_type = SLL; req1_tag = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("cont_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         check("cont_id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
         check("cont_result", rsp_result, (i % 2 == 1) ? 32'h8000_0000 : 32'h0800_0000);
      end
      req1_valid = 1'b0;

      // Single-port SRA (drains the previous response in the same cycle).
      req0_s1 = 32'h8000_0000; req0_s2 = 5'd4; req0_type = SRA; req0_tag = 4'd3;
      #1;
      check("sra_ready0", {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check("sra_valid", {31'd0, rsp_valid}, 32'd1);
      check("sra_result", rsp_result, 32'hF800_0000);
      check("sra_id", {31'd0, rsp_id}, 32'd0);
      check("sra_tag", {28'd0, rsp_tag}, 32'd3);
      check("sra_err", {31'd0, rsp_err}, 32'd0);
      tick();
      check("drain_valid", {31'd0, rsp_valid}, 32'd0);

      // Backpressure: hold a port-1 response, then drain and accept together.
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_s1 = 32'd1; req1_s2 = 5'd3; req1_type = SLL; req1_tag = 4'd5;
      tick();
      req1_s1 = 32'd3; req1_s2 = 5'd2; req1_tag = 4'd6;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_ready0", {31'd0, req0_ready}, 32'd0);
         check("bp_ready1", {31'd0, req1_ready}, 32'd0);
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_result", rsp_result, 32'd8);
         check("bp_id", {31'd0, rsp_id}, 32'd1);
         check("bp_tag", {28'd0, rsp_tag}, 32'd5);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      check("bp_after_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_after_result", rsp_result, 32'd12);
      check("bp_after_tag", {28'd0, rsp_tag}, 32'd6);

      // Illegal types: multi-hot (SLL wins) and zero.
      req0_valid = 1'b1; req0_s1 = 32'h0000_00F0; req0_s2 = 5'd4; req0_type = 3'b011; req0_tag = 4'd1;
      tick();
      check("multi_result", rsp_result, 32'h0000_0F00);
      check("multi_err", {31'd0, rsp_err}, 32'd1);
      req0_s1 = 32'hFFFF_FFFF; req0_s2 = 5'd0; req0_type = 3'b000; req0_tag = 4'd2;
      tick();
      req0_valid = 1'b0;
      check("zero_result", rsp_result, 32'd0);
      check("zero_err", {31'd0, rsp_err}, 32'd1);

      // Flush: pending port-1 response (prio now 0), port 0 presents during flush.
      req1_valid = 1'b1; req1_s1 = 32'h100; req1_s2 = 5'd4; req1_type = SRL; req1_tag = 4'd7;
      tick();
      req1_valid = 1'b0;
      check("flush_pre_valid", {31'd0, rsp_valid}, 32'd1);
      check("flush_pre_result", rsp_result, 32'h10);
      req0_valid = 1'b1; req0_s1 = 32'd5; req0_s2 = 5'd1; req0_type = SLL; req0_tag = 4'd9;
      flush = 1'b1;
      #1;
      check("flush_ready0", {31'd0, req0_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_valid", {31'd0, rsp_valid}, 32'd0);
      req1_valid = 1'b1;
      #1;
      check("flush_prio_ready0", {31'd0, req0_ready}, 32'd1);
      check("flush_prio_ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      check("flush_next_result", rsp_result, 32'd10);

      // Async reset mid-cycle with a response held and prio at 1.
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      check("ar_pre_valid", {31'd0, rsp_valid}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("ar_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("ar_result", rsp_result, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("ar_prio_ready0", {31'd0, req0_ready}, 32'd1);
      check("ar_prio_ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      tick();
      cmp_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single execute-stage barrel shifter between two requesters: port 0 is the main ALU issue path and port 1 is the CSR/address-generation side path. A round-robin arbiter accepts at most one shift per cycle over valid/ready handshakes and drives the combinational shifter. The arbiter captures the result, requester id and tag in a one-entry output register with its own valid/ready handshake. It sits between issue and writeback-select in the execute stage.

## Interface
- TAG_W, 4, width of the opaque tag carried from request to response.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline flush; kills the held response and blocks acceptance this cycle.
- reqN_valid  in  1  (N = 0, 1) request N is presented.
- reqN_ready  out  1  request N is accepted this cycle.
- reqN_s1  in  32  shift operand, interpreted as signed for SRA.
- reqN_s2  in  5  shift amount, 0–31.
- reqN_type  in  3  one-hot shift type: 3'b001 SLL, 3'b010 SRL, 3'b100 SRA.
- reqN_tag  in  TAG_W  opaque tag.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  32  shift result.
- rsp_id  out  1  index of the requester that issued the shift.
- rsp_tag  out  TAG_W  tag of the issuing request.
- rsp_err  out  1  reqN_type was not exactly one-hot.

## Operation
- slot_free = !rsp_valid || rsp_ready.
- **Grant selection** (combinational; only when slot_free && !flush):
  - If only one port is valid, it is granted.
  - If both ports are valid, the port named by the priority bit `prio` is granted.
- reqN_ready = granted(N).
  - ready depends combinationally on both valids, rsp_ready and flush.
  - ready never depends on the requester's own operands.
- **On accept:**
  - Register the shifter output into rsp_result.
  - Set rsp_id = N, rsp_tag = reqN_tag, rsp_err = (type not one-hot), rsp_valid = 1.
  - Set prio = ~N.
- `prio` is updated only on an accept.
  - A lone requester therefore keeps priority with the other port, so that port wins the next contention.
- **Shift semantics, priority-decoded on type:**
  - bit0 → s1 << s2.
  - else bit1 → logical s1 >> s2.
  - else bit2 → arithmetic s1 >>> s2.
  - type 3'b000 → result 0.
  - For multi-hot types the lowest set bit wins; rsp_err is set in both the multi-hot and the zero case.
- **Response register:**
  - rsp_valid clears when rsp_ready is high and no new accept occurs.
  - Simultaneous drain and accept: the register is replaced with the new entry and rsp_valid stays 1.
  - While rsp_valid && !rsp_ready, the register and all rsp_* outputs are held stable and both readies are 0.
- **flush:**
  - Next edge rsp_valid = 0.
  - No accept in the flush cycle; requesters see ready = 0.
  - prio is unchanged.
  - rsp_result, rsp_id and rsp_tag contents are don't-care after flush.
- **Reset values:** rsp_valid 0, rsp_result 0, rsp_id 0, rsp_tag 0, rsp_err 0, prio 0 (port 0 favoured).
  - reqN_ready is 0 while rst is asserted.
- **Reset mid-operation:** an in-flight response is dropped and an unaccepted request is not retained; requesters must re-present after reset.

## Timing
- Latency: accept at edge k → rsp_valid high after edge k, i.e. one cycle.
- Throughput: one shift per cycle sustained when rsp_ready is held high.
- No combinational path from any reqN_* input to any rsp_* output.
- Critical path: the shifter plus the result register setup. The grant mux sits ahead of the shifter, so operand selection uses the grant and not prio alone.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; a waiting port is granted within 2 accepts.

## Structure
- Shared execute package holds:
  - Shift-type constants: SHIFT_SLL = 3'b001, SHIFT_SRL = 3'b010, SHIFT_SRA = 3'b100.
  - A typedef for the request bundle {s1, s2, type, tag}.
- One sub-module instance: the existing combinational `shift` unit, fed by the grant-muxed operands.
- Arbitration, `prio` and the response register stay in this block; no further sub-modules.

## Test plan
- **Single-port SRA.** Port 0 sends s1 0x8000_0000, s2 4, SRA, tag 3, with rsp_ready = 1. Required: one cycle later rsp_result = 0xF800_0000, rsp_id 0, rsp_tag 3, rsp_err 0.
- **Contention.** Both ports valid for 4 cycles from reset: port 0 SRL 0x8000_0000 by 4, port 1 SLL 0x1 by 31. Required: grants 0,1,0,1; results 0x0800_0000 and 0x8000_0000 alternate.
- **Backpressure.** rsp_ready held 0 for 3 cycles with port 1 valid. Required:
  - rsp_* outputs stable and both readies 0 throughout.
  - When rsp_ready rises, that cycle accepts port 1 and rsp_valid stays 1.
- **Illegal type.** type 3'b011 with s1 0x0000_00F0 and s2 4. Required: rsp_result 0x0000_0F00 (SLL wins), rsp_err 1. Also type 3'b000 → result 0, rsp_err 1.
- **Flush.** flush with a response pending and port 0 valid. Required: ready 0 that cycle, rsp_valid 0 next cycle, prio unchanged.
- **Async reset.** rst asserted mid-cycle with rsp_valid 1. Required: rsp_valid drops immediately without a clock edge; prio = 0 after release.
